// File: rtl/scalar_issue_fust_pkg.sv
// rtl/scalar_issue_fust_pkg.sv - shared types for the scalar issue stage and its FU status table
package scalar_issue_fust_pkg;

    localparam int NUM_SFU = 3;
    localparam int FU_S_W  = 2;
    localparam int TAG_W   = FU_S_W;

    localparam int SFU_ALU    = 0;
    localparam int SFU_LDST   = 1;
    localparam int SFU_BRANCH = 2;

    typedef logic [2:0]       fu_scalar_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [4:0]       reg_idx_t;
    typedef logic [31:0]      word_t;
    typedef logic [11:0]      imm_t;
    typedef logic             wb_t;
    typedef logic [3:0]       alu_ctr_t;
    typedef logic [3:0]       branch_ctr_t;
    typedef logic [3:0]       ldst_ctr_t;

    localparam fu_scalar_t FU_ALU    = 3'd0;
    localparam fu_scalar_t FU_LDST   = 3'd1;
    localparam fu_scalar_t FU_BRANCH = 3'd2;
    localparam tag_t       SFU_TAG_READY = '0;

    typedef enum logic [1:0] {
        FUST_EMTPY = 2'd0,
        FUST_WAIT  = 2'd1,
        FUST_RDY   = 2'd2,
        FUST_EX    = 2'd3
    } fust_state_e;

    typedef struct packed {
        alu_ctr_t    fu_alu_ctr;
        branch_ctr_t fu_branch_ctr;
        ldst_ctr_t   fu_ldst_ctr;
    } ctr_t;

    typedef struct packed {
        reg_idx_t rd;
        reg_idx_t rs1;
        reg_idx_t rs2;
        imm_t     imm;
        tag_t     t1;
        tag_t     t2;
    } fust_s_row_t;

    typedef struct packed {
        fu_scalar_t  fu_s;
        fust_s_row_t fust;
        ctr_t        ctr;
        wb_t         wb;
    } dispatch_t;

    typedef struct packed {
        fust_state_e state;
        fust_s_row_t row;
        ctr_t        ctr;
        wb_t         wb;
    } fust_s_entry_t;

    typedef struct packed {
        reg_idx_t rd;
        reg_idx_t rs1;
        reg_idx_t rs2;
        alu_ctr_t ctr;
        wb_t      wb;
    } fu_alu_t;

    typedef struct packed {
        reg_idx_t    rs1;
        reg_idx_t    rs2;
        branch_ctr_t ctr;
    } fu_branch_t;

    typedef struct packed {
        reg_idx_t  rd;
        reg_idx_t  rs1;
        reg_idx_t  rs2;
        ldst_ctr_t ctr;
        word_t     imm;
        wb_t       wb;
    } fu_ldst_t;

    typedef struct packed {
        fu_alu_t    fu_alu;
        fu_branch_t fu_branch;
        fu_ldst_t   fu_ldst;
        word_t      mat_op;
    } issue_t;

    // Producer tag of an FU: 0 is reserved for "operand ready".
    function automatic tag_t sfu_tag(input fu_scalar_t fu);
        logic [2:0] t;
        t = fu + 3'd1;
        return t[TAG_W-1:0];
    endfunction

endpackage

// File: rtl/scalar_issue_fust_row.sv
// rtl/scalar_issue_fust_row.sv - one FU status row: state machine, tag capture and wakeup
module sfust_row
    import scalar_issue_fust_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          alloc_i,
    input  fust_s_row_t   row_i,
    input  ctr_t          ctr_i,
    input  wb_t           wb_i,
    input  logic          wake_i,
    input  tag_t          wake_tag_i,
    input  logic          flush_i,
    input  logic          fu_ready_i,
    input  logic          done_i,
    output fust_s_entry_t entry_o,
    output logic          fire_o
);

    fust_s_entry_t entry_q, entry_d;
    tag_t          t1_woken, t2_woken, t1_in, t2_in;

    always_comb begin
        t1_woken = (wake_i && entry_q.row.t1 == wake_tag_i) ? SFU_TAG_READY : entry_q.row.t1;
        t2_woken = (wake_i && entry_q.row.t2 == wake_tag_i) ? SFU_TAG_READY : entry_q.row.t2;
        t1_in    = (wake_i && row_i.t1 == wake_tag_i) ? SFU_TAG_READY : row_i.t1;
        t2_in    = (wake_i && row_i.t2 == wake_tag_i) ? SFU_TAG_READY : row_i.t2;
        fire_o   = (entry_q.state == FUST_RDY) && fu_ready_i;
        entry_d  = entry_q;
        case (entry_q.state)
            FUST_EMTPY: begin
                if (alloc_i) begin
                    entry_d.row    = row_i;
                    entry_d.row.t1 = t1_in;
                    entry_d.row.t2 = t2_in;
                    entry_d.ctr    = ctr_i;
                    entry_d.wb     = wb_i;
                    entry_d.state  = (t1_in == SFU_TAG_READY && t2_in == SFU_TAG_READY)
                                     ? FUST_RDY : FUST_WAIT;
                end
            end
            FUST_WAIT: begin
                entry_d.row.t1 = t1_woken;
                entry_d.row.t2 = t2_woken;
                if (flush_i)
                    entry_d.state = FUST_EMTPY;
                else if (t1_woken == SFU_TAG_READY && t2_woken == SFU_TAG_READY)
                    entry_d.state = FUST_RDY;
            end
            // Issue beats a coincident flush: the op is already handed to the FU.
            FUST_RDY: begin
                if (fu_ready_i)
                    entry_d.state = FUST_EX;
                else if (flush_i)
                    entry_d.state = FUST_EMTPY;
            end
            FUST_EX: begin
                if (done_i)
                    entry_d.state = FUST_EMTPY;
            end
            default: entry_d.state = FUST_EMTPY;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            entry_q <= '{state: FUST_EMTPY, default: '0};
        else
            entry_q <= entry_d;
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/scalar_issue_fust.sv
// rtl/scalar_issue_fust.sv - scalar issue stage: per-FU status rows, wakeup and registered issue payloads
module scalar_issue_fust
    import scalar_issue_fust_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               disp_valid,
    input  dispatch_t          disp,
    output logic [NUM_SFU-1:0] disp_ready,
    input  logic [NUM_SFU-1:0] fu_ready,
    input  logic               wb_valid,
    input  fu_scalar_t         wb_fu,
    input  logic               flush,
    output logic [NUM_SFU-1:0] issue_valid,
    output issue_t             issue,
    output fust_state_e        row_state [NUM_SFU]
);

    fust_s_entry_t      entry [NUM_SFU];
    logic [NUM_SFU-1:0] fire;
    logic [NUM_SFU-1:0] disp_hit;
    logic               wake;
    tag_t               wake_tag;
    issue_t             issue_q, issue_d;
    logic [NUM_SFU-1:0] issue_valid_q;
    logic               unused_bits;

    // Out-of-range FU ids would alias onto valid tags after truncation.
    assign wake     = wb_valid && (wb_fu < 3'(NUM_SFU));
    assign wake_tag = sfu_tag(wb_fu);

    for (genvar i = 0; i < NUM_SFU; i++) begin : g_row
        assign disp_hit[i] = (disp.fu_s == 3'(i));

        sfust_row u_row (
            .CLK        (CLK),
            .RST        (RST),
            .alloc_i    (disp_valid && !flush && disp_hit[i]),
            .row_i      (disp.fust),
            .ctr_i      (disp.ctr),
            .wb_i       (disp.wb),
            .wake_i     (wake),
            .wake_tag_i (wake_tag),
            .flush_i    (flush),
            .fu_ready_i (fu_ready[i]),
            .done_i     (wb_valid && wb_fu == 3'(i)),
            .entry_o    (entry[i]),
            .fire_o     (fire[i])
        );

        assign disp_ready[i] = (entry[i].state == FUST_EMTPY);
        assign row_state[i]  = entry[i].state;
    end

    always_comb begin
        issue_d        = issue_q;
        issue_d.mat_op = '0;
        if (fire[SFU_ALU]) begin
            issue_d.fu_alu.rd  = entry[SFU_ALU].row.rd;
            issue_d.fu_alu.rs1 = entry[SFU_ALU].row.rs1;
            issue_d.fu_alu.rs2 = entry[SFU_ALU].row.rs2;
            issue_d.fu_alu.ctr = entry[SFU_ALU].ctr.fu_alu_ctr;
            issue_d.fu_alu.wb  = entry[SFU_ALU].wb;
        end
        if (fire[SFU_BRANCH]) begin
            issue_d.fu_branch.rs1 = entry[SFU_BRANCH].row.rs1;
            issue_d.fu_branch.rs2 = entry[SFU_BRANCH].row.rs2;
            issue_d.fu_branch.ctr = entry[SFU_BRANCH].ctr.fu_branch_ctr;
        end
        if (fire[SFU_LDST]) begin
            issue_d.fu_ldst.rd  = entry[SFU_LDST].row.rd;
            issue_d.fu_ldst.rs1 = entry[SFU_LDST].row.rs1;
            issue_d.fu_ldst.rs2 = entry[SFU_LDST].row.rs2;
            issue_d.fu_ldst.ctr = entry[SFU_LDST].ctr.fu_ldst_ctr;
            issue_d.fu_ldst.imm = {{20{entry[SFU_LDST].row.imm[11]}}, entry[SFU_LDST].row.imm};
            issue_d.fu_ldst.wb  = entry[SFU_LDST].wb;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            issue_q       <= '0;
            issue_valid_q <= '0;
        end else begin
            issue_q       <= issue_d;
            issue_valid_q <= fire;
        end
    end

    assign issue       = issue_q;
    assign issue_valid = issue_valid_q;

    // Row fields that no FU payload carries.
    assign unused_bits = ^{entry[SFU_ALU].row.t1, entry[SFU_ALU].row.t2, entry[SFU_ALU].row.imm,
                           entry[SFU_ALU].ctr.fu_branch_ctr, entry[SFU_ALU].ctr.fu_ldst_ctr,
                           entry[SFU_LDST].row.t1, entry[SFU_LDST].row.t2,
                           entry[SFU_LDST].ctr.fu_alu_ctr, entry[SFU_LDST].ctr.fu_branch_ctr,
                           entry[SFU_BRANCH].row.t1, entry[SFU_BRANCH].row.t2,
                           entry[SFU_BRANCH].row.rd, entry[SFU_BRANCH].row.imm, entry[SFU_BRANCH].wb,
                           entry[SFU_BRANCH].ctr.fu_alu_ctr, entry[SFU_BRANCH].ctr.fu_ldst_ctr};

    a_disp_into_busy_row: assert property (@(posedge CLK) disable iff (RST)
        !(disp_valid && !flush && |(disp_hit & ~disp_ready)));

endmodule

// File: tb/tb_scalar_issue_fust.sv
// tb/tb_scalar_issue_fust.sv - randomized bench for scalar_issue_fust against a behavioural table model
module tb_scalar_issue_fust;
    import scalar_issue_fust_pkg::*;

    logic               CLK = 1'b0;
    logic               RST;
    logic               disp_valid;
    dispatch_t          disp;
    logic [NUM_SFU-1:0] disp_ready;
    logic [NUM_SFU-1:0] fu_ready;
    logic               wb_valid;
    fu_scalar_t         wb_fu;
    logic               flush;
    logic [NUM_SFU-1:0] issue_valid;
    issue_t             issue;
    fust_state_e        row_state [NUM_SFU];

    scalar_issue_fust dut (
        .CLK         (CLK),
        .RST         (RST),
        .disp_valid  (disp_valid),
        .disp        (disp),
        .disp_ready  (disp_ready),
        .fu_ready    (fu_ready),
        .wb_valid    (wb_valid),
        .wb_fu       (wb_fu),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue       (issue),
        .row_state   (row_state)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: 0 empty, 1 waiting on producers, 2 ready, 3 executing.
    int        m_st [NUM_SFU];
    int        m_t1 [NUM_SFU];
    int        m_t2 [NUM_SFU];
    dispatch_t m_row [NUM_SFU];
    logic [2:0] m_iv;
    issue_t    m_issue;

    function automatic void model_reset();
        for (int i = 0; i < NUM_SFU; i++) begin
            m_st[i] = 0; m_t1[i] = 0; m_t2[i] = 0; m_row[i] = '0;
        end
        m_iv = '0;
        m_issue = '0;
    endfunction

    function automatic void model_step();
        int wtag;
        int s;
        logic [2:0] fired;
        wtag  = (wb_valid && wb_fu < 3) ? int'(wb_fu) + 1 : -1;
        fired = '0;
        for (int i = 0; i < NUM_SFU; i++) begin
            if (m_st[i] == 0) begin
                if (disp_valid && !flush && int'(disp.fu_s) == i) begin
                    m_row[i] = disp;
                    m_t1[i] = (int'(disp.fust.t1) == wtag) ? 0 : int'(disp.fust.t1);
                    m_t2[i] = (int'(disp.fust.t2) == wtag) ? 0 : int'(disp.fust.t2);
                    m_st[i] = (m_t1[i] == 0 && m_t2[i] == 0) ? 2 : 1;
                end
            end else if (m_st[i] == 1) begin
                if (flush) m_st[i] = 0;
                else begin
                    if (m_t1[i] == wtag) m_t1[i] = 0;
                    if (m_t2[i] == wtag) m_t2[i] = 0;
                    if (m_t1[i] == 0 && m_t2[i] == 0) m_st[i] = 2;
                end
            end else if (m_st[i] == 2) begin
                if (fu_ready[i]) begin m_st[i] = 3; fired[i] = 1'b1; end
                else if (flush) m_st[i] = 0;
            end else begin
                if (wb_valid && int'(wb_fu) == i) m_st[i] = 0;
            end
        end
        m_iv = fired;
        if (fired[0]) begin
            m_issue.fu_alu.rd  = m_row[0].fust.rd;
            m_issue.fu_alu.rs1 = m_row[0].fust.rs1;
            m_issue.fu_alu.rs2 = m_row[0].fust.rs2;
            m_issue.fu_alu.ctr = m_row[0].ctr.fu_alu_ctr;
            m_issue.fu_alu.wb  = m_row[0].wb;
        end
        if (fired[1]) begin
            s = int'(m_row[1].fust.imm);
            if (s >= 2048) s = s - 4096;
            m_issue.fu_ldst.rd  = m_row[1].fust.rd;
            m_issue.fu_ldst.rs1 = m_row[1].fust.rs1;
            m_issue.fu_ldst.rs2 = m_row[1].fust.rs2;
            m_issue.fu_ldst.ctr = m_row[1].ctr.fu_ldst_ctr;
            m_issue.fu_ldst.imm = word_t'(s);
            m_issue.fu_ldst.wb  = m_row[1].wb;
        end
        if (fired[2]) begin
            m_issue.fu_branch.rs1 = m_row[2].fust.rs1;
            m_issue.fu_branch.rs2 = m_row[2].fust.rs2;
            m_issue.fu_branch.ctr = m_row[2].ctr.fu_branch_ctr;
        end
    endfunction

    task automatic compare_all();
        logic [2:0] exp_ready;
        for (int i = 0; i < NUM_SFU; i++) begin
            check($sformatf("row_state%0d", i), row_state[i], m_st[i]);
            exp_ready[i] = (m_st[i] == 0);
        end
        check("disp_ready", disp_ready, exp_ready);
        check("issue_valid", issue_valid, m_iv);
        check("issue_payload", issue, m_issue);
    endtask

    task automatic step(input logic dv, input dispatch_t d, input logic [2:0] fr,
                        input logic wv, input fu_scalar_t wf, input logic fl);
        disp_valid = dv; disp = d; fu_ready = fr; wb_valid = wv; wb_fu = wf; flush = fl;
        model_step();
        @(posedge CLK); #1;
        compare_all();
    endtask

    task automatic go_idle();
        disp_valid = 0; disp = '0; fu_ready = '0; wb_valid = 0; wb_fu = '0; flush = 0;
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < NUM_SFU; i++)
            check($sformatf("rst_state%0d", i), row_state[i], FUST_EMTPY);
        check("rst_disp_ready", disp_ready, 3'b111);
        check("rst_issue_valid", issue_valid, 3'b000);
        check("rst_issue", issue, '0);
    endtask

    // Asynchronous reset raised mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        go_idle();
        #3; RST = 1'b1; #1;
        check_reset_outputs();
        model_reset();
        @(posedge CLK); #1; RST = 1'b0;
    endtask

    function automatic dispatch_t rand_disp(input fu_scalar_t fu);
        dispatch_t d;
        d.fu_s     = fu;
        d.fust.rd  = 5'($urandom);
        d.fust.rs1 = 5'($urandom);
        d.fust.rs2 = 5'($urandom);
        d.fust.imm = 12'($urandom);
        d.fust.t1  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
        d.fust.t2  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
        d.ctr.fu_alu_ctr    = 4'($urandom);
        d.ctr.fu_branch_ctr = 4'($urandom);
        d.ctr.fu_ldst_ctr   = 4'($urandom);
        d.wb = 1'($urandom);
        return d;
    endfunction

    initial begin
        dispatch_t  d;
        fu_scalar_t fu;
        fu_scalar_t wf;
        logic       dv, wv;
        int         ex_list[$];

        RST = 1'b1;
        go_idle();
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs();
        RST = 1'b0;

        // Independent ALU op: issue strobe two edges after dispatch.
        d = '0; d.fu_s = FU_ALU; d.fust.rd = 5'd5; d.fust.rs1 = 5'd1; d.fust.rs2 = 5'd2;
        d.ctr.fu_alu_ctr = 4'h3; d.wb = 1'b1;
        step(1'b1, d, 3'b111, 1'b0, FU_ALU, 1'b0);
        check("alu_rdy", row_state[0], FUST_RDY);
        check("alu_no_issue_yet", issue_valid, 3'b000);
        step(1'b0, '0, 3'b111, 1'b0, FU_ALU, 1'b0);
        check("alu_issue", issue_valid, 3'b001);
        check("alu_rd", issue.fu_alu.rd, 5);
        check("alu_rs1", issue.fu_alu.rs1, 1);
        check("alu_rs2", issue.fu_alu.rs2, 2);
        step(1'b0, '0, 3'b111, 1'b0, FU_ALU, 1'b0);
        check("alu_pulse_once", issue_valid, 3'b000);
        check("alu_ex", row_state[0], FUST_EX);
        do_reset();

        // Dispatch bypass: incoming tag matches the concurrent writeback.
        d = '0; d.fu_s = FU_BRANCH; d.fust.t2 = 2'd2;
        step(1'b1, d, 3'b000, 1'b1, FU_LDST, 1'b0);
        check("bypass_rdy", row_state[2], FUST_RDY);
        step(1'b0, '0, 3'b000, 1'b0, FU_ALU, 1'b1);
        check("flush_rdy_empty", row_state[2], FUST_EMTPY);

        // ALU held ready while its FU stalls, then a single issue.
        d = '0; d.fu_s = FU_ALU; d.fust.rd = 5'd9;
        step(1'b1, d, 3'b000, 1'b0, FU_ALU, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, '0, 3'b000, 1'b0, FU_ALU, 1'b0);
            check("stall_ready0", disp_ready[0], 1'b0);
            check("stall_no_issue", issue_valid, 3'b000);
        end
        step(1'b0, '0, 3'b001, 1'b0, FU_ALU, 1'b0);
        check("stall_release", issue_valid, 3'b001);
        step(1'b0, '0, 3'b001, 1'b1, FU_ALU, 1'b0);
        check("stall_single", issue_valid, 3'b000);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) do_reset();
            fu = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            dv = 1'($urandom);
            if (fu < 3 && m_st[fu] != 0) dv = 1'b0;
            ex_list.delete();
            for (int i = 0; i < NUM_SFU; i++)
                if (m_st[i] == 3) ex_list.push_back(i);
            wv = 1'b0; wf = '0;
            if (ex_list.size() > 0 && $urandom_range(0, 1) == 1) begin
                wv = 1'b1;
                wf = 3'(ex_list[$urandom_range(0, ex_list.size() - 1)]);
            end else if ($urandom_range(0, 4) == 0) begin
                wv = 1'b1;
                wf = 3'($urandom_range(0, 7));
            end
            step(dv, rand_disp(fu), 3'($urandom) | 3'($urandom), wv, wf,
                 $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scalar_issue_fust.md
Name: scalar_issue_fust

Overview:
- Scalar issue stage: sits directly downstream of dispatch and consumes dispatch_t.
- Holds the scalar functional-unit status table with one row per scalar FU: ALU, LD_ST and BRANCH.
- Tracks operand-producer tags, wakes rows on FU writeback, and issues ready rows into registered fu_alu_t / fu_branch_t / fu_ldst_t payloads (the scalar fields of issue_t).
- Matrix and GEMM issue are handled elsewhere.

Parameters:
- NUM_SFU, 3, number of scalar FUs / table rows (index = fu_scalar_t value).
- TAG_W, FU_S_W (2), producer-tag width. Tag 0 = operand ready; tag k = awaiting FU k-1.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- disp_valid  in  1  dispatch presents an instruction this cycle.
- disp  in  dispatch_t  fu_s, fust_s row (rd, rs1, rs2, imm, t1, t2), ctr structs, wb.
- disp_ready  out  NUM_SFU  per-FU row free (combinational from state).
- fu_ready  in  NUM_SFU  FU can accept an issue this cycle.
- wb_valid  in  1  scalar FU result broadcast.
- wb_fu  in  3  fu_scalar_t of the completing FU.
- flush  in  1  branch-resolve squash.
- issue_valid  out  NUM_SFU  registered per-FU issue strobe.
- issue  out  issue_t  registered payload; only the fu_alu, fu_branch and fu_ldst fields are driven, matrix fields tied 0.
- row_state  out  NUM_SFU x fust_state_e  debug/verification visibility.

Behaviour:
Reset:
- All rows go to FUST_EMTPY with busy=0 and tags 0.
- issue_valid=0, issue=0, disp_ready=all 1.
- RST asserted mid-operation discards every row immediately, including rows in FUST_EX.

Row states (fust_state_e) per row i:
- EMPTY -> WAIT: disp_valid && disp.fu_s==i. Captures rd/rs1/rs2/imm/t1/t2/ctr/wb; busy=1.
- EMPTY -> RDY (same edge): the captured tags are both 0 after wakeup bypass.
- WAIT -> RDY: both stored tags become 0.
- RDY -> EX: fu_ready[i]. issue_valid[i]=1 for exactly one cycle (the cycle after the RDY->EX edge) with payload from the row.
- EX -> EMPTY: wb_valid && wb_fu==i. BRANCH completes the same way (its wb asserted at resolve).

Dispatch handshake:
- disp_ready[i] = (state[i]==EMPTY). Dispatch never accepts into a row freed the same cycle; it takes one bubble.
- disp_valid with disp.fu_s targeting a non-EMPTY row is a protocol error. The row is not overwritten; an assertion fires.
- disp.fu_s >= NUM_SFU is ignored.

Wakeup:
- On wb_valid, every busy row with t1==wb_fu+1 clears t1, and likewise for t2.
- Bypass: a dispatch in the same cycle whose incoming t1/t2 equals wb_fu+1 is stored as 0.
- A row woken in cycle N is RDY at N+1 and may reach EX at N+1 if fu_ready.
- Issue latency: minimum 2 edges from dispatch (dispatch->RDY, RDY->EX), issue_valid high after the 2nd edge.

Parallel issue:
- Rows are independent, so up to NUM_SFU issues per cycle.
- No arbitration is needed because each FU owns one row.

Flush:
- Rows in WAIT or RDY go to EMPTY next edge.
- EX rows are unaffected.
- A flush coincident with disp_valid drops the dispatch.
- A flush coincident with RDY->EX: issue wins, and the row goes to EX.

Payload mapping:
- fu_alu: rd, rs1, rs2, fu_alu_ctr, wb.
- fu_branch: rs1, rs2, fu_branch_ctr.
- fu_ldst: rd, rs1, rs2, fu_ldst_ctr (imm sign-extended from row imm[11:0] into word_t), wb.
- Payload holds its value when issue_valid=0.

Decomposition:
- Add to datapath_pkg: SFU_TAG_READY constant (0), function sfu_tag(fu_scalar_t) returning fu+1, and a struct fust_s_entry_t { fust_state_e state; fust_s_row_t row; ctr union fields; wb_t wb }.
- Sub-module sfust_row (one row's FSM, tag wakeup and capture) instantiated NUM_SFU times. The top handles decode, flush fan-out and payload muxing.

Test Plan:
- Reset: pulse RST during FUST_EX on ALU -> all row_state EMPTY, issue_valid=000, disp_ready=111 in same cycle.
- Independent ALU op, t1=t2=0, fu_ready=111 -> issue_valid[0]=1 exactly one cycle, 2 edges after dispatch; rd=5, rs1=1, rs2=2 echoed.
- LD_ST dispatched with t1=1 (waiting on ALU), ALU in EX; wb_valid, wb_fu=ALU at cycle N -> LD_ST RDY at N+1, issues N+1 -> issue_valid[1] at N+2; ALU row EMPTY at N+1.
- Same-cycle bypass: dispatch BRANCH with t2=2 while wb_valid, wb_fu=LD_ST -> stored t2=0, row enters RDY directly.
- flush with ALU in WAIT, LD_ST in EX -> ALU EMPTY next cycle, LD_ST stays EX until its wb.
- fu_ready[0]=0 for 4 cycles with ALU RDY -> no issue, disp_ready[0]=0; fu_ready released -> single issue_valid[0] pulse.
